// File: rtl/pet_loader_pkg.sv
// rtl/pet_loader_pkg.sv - shared state type, widths and default download indices for the loader
package pet_loader_pkg;

    localparam int DMA_AW = 16;
    localparam int DMA_DW = 8;
    localparam int PTR_KW = 3;

    localparam logic [7:0] DEF_PRG_INDEX = 8'h41;
    localparam logic [7:0] DEF_ROM_INDEX = 8'h00;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DATA,
        ROMD,
        PTR_LO,
        PTR_HI
    } loader_state_t;

endpackage

// File: rtl/loader_wbuf.sv
// rtl/loader_wbuf.sv - one-entry hold buffer presenting a write to the DMA port until accepted
module loader_wbuf
    import pet_loader_pkg::*;
(
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              push,
    input  logic [DMA_AW-1:0] addr,
    input  logic [DMA_DW-1:0] data,
    input  logic              flush,
    input  logic              dma_ready,
    output logic              full,
    output logic [DMA_AW-1:0] dma_addr,
    output logic [DMA_DW-1:0] dma_data,
    output logic              dma_we
);

    logic              full_q;
    logic [DMA_AW-1:0] addr_q;
    logic [DMA_DW-1:0] data_q;

    // Hold one write; a push is only taken while empty, flush abandons the held entry.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            full_q <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else if (flush) begin
            full_q <= 1'b0;
        end else if (full_q) begin
            if (dma_ready) begin
                full_q <= 1'b0;
            end
        end else if (push) begin
            full_q <= 1'b1;
            addr_q <= addr;
            data_q <= data;
        end
    end

    assign full     = full_q;
    assign dma_we   = full_q;
    assign dma_addr = addr_q;
    assign dma_data = data_q;

endmodule

// File: rtl/prg_loader.sv
// rtl/prg_loader.sv - PRG/ROM download loader from data_io into the pet2001hw DMA port
module prg_loader
    import pet_loader_pkg::*;
#(
    parameter int          IOCTL_AW   = 25,
    parameter logic [7:0]  PRG_INDEX  = DEF_PRG_INDEX,
    parameter logic [7:0]  ROM_INDEX  = DEF_ROM_INDEX,
    parameter logic [15:0] RAM_LIMIT  = 16'h8000,
    parameter logic [15:0] ROM_LO     = 16'h0400,
    parameter logic [15:0] ROM_HI     = 16'h8000,
    parameter logic [15:0] ROM_OFFSET = 16'h8000,
    parameter logic [15:0] PTR_BASE   = 16'h002A,
    parameter int          N_PTRS     = 3
) (
    input  logic                clk_sys,
    input  logic                reset_n,
    input  logic                ioctl_download,
    input  logic [7:0]          ioctl_index,
    input  logic                ioctl_wr,
    input  logic [IOCTL_AW-1:0] ioctl_addr,
    input  logic [7:0]          ioctl_dout,
    output logic                ioctl_wait,
    output logic [15:0]         dma_addr,
    output logic [7:0]          dma_data,
    output logic                dma_we,
    input  logic                dma_ready,
    output logic                busy,
    output logic [15:0]         prg_end,
    output logic                overflow,
    output logic                err_drop
);

    loader_state_t     state_q;
    loader_state_t     state_d;
    loader_state_t     start_state;
    logic              dl_q;
    logic              dl_rise;
    logic              full;
    logic              wr_ok;
    logic              in_win;
    logic              last_ptr;
    logic              push;
    logic              flush;
    logic [DMA_AW-1:0] push_addr;
    logic [DMA_DW-1:0] push_data;
    logic [DMA_AW-1:0] addr_q;
    logic [DMA_AW-1:0] ptr_addr;
    logic [PTR_KW-1:0] ptr_k;

    assign dl_rise     = ioctl_download & ~dl_q;
    assign wr_ok       = ioctl_wr & ~full;
    assign in_win      = (ioctl_addr >= IOCTL_AW'(ROM_LO)) && (ioctl_addr < IOCTL_AW'(ROM_HI));
    assign ptr_addr    = PTR_BASE + DMA_AW'({ptr_k, 1'b0});
    assign last_ptr    = (ptr_k == PTR_KW'(N_PTRS - 1));
    assign start_state = (ioctl_index == PRG_INDEX) ? HDR :
                         (ioctl_index == ROM_INDEX) ? ROMD : IDLE;

    // State register.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus the write offered to the hold buffer.
    always_comb begin
        state_d   = state_q;
        push      = 1'b0;
        push_addr = '0;
        push_data = '0;
        flush     = 1'b0;
        case (state_q)
            IDLE: begin
                if (dl_rise) state_d = start_state;
            end
            HDR: begin
                if (!ioctl_download) begin
                    state_d = IDLE;
                end else if (wr_ok && ioctl_addr == IOCTL_AW'(1)) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (wr_ok && addr_q < RAM_LIMIT) begin
                    push      = 1'b1;
                    push_addr = addr_q;
                    push_data = ioctl_dout;
                end
                if (!ioctl_download) state_d = PTR_LO;
            end
            ROMD: begin
                if (wr_ok && in_win) begin
                    push      = 1'b1;
                    push_addr = ioctl_addr[15:0] + ROM_OFFSET;
                    push_data = ioctl_dout;
                end
                // Leave only once the last image byte has been accepted.
                if (!ioctl_download && !full && !push) state_d = IDLE;
            end
            PTR_LO: begin
                if (dl_rise) begin
                    flush   = 1'b1;
                    state_d = start_state;
                end else if (!full) begin
                    push      = 1'b1;
                    push_addr = ptr_addr;
                    push_data = addr_q[7:0];
                    state_d   = PTR_HI;
                end
            end
            PTR_HI: begin
                if (dl_rise) begin
                    flush   = 1'b1;
                    state_d = start_state;
                end else if (!full) begin
                    push      = 1'b1;
                    push_addr = ptr_addr + 16'd1;
                    push_data = addr_q[15:8];
                    state_d   = last_ptr ? IDLE : PTR_LO;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Load address, pointer index, end pointer and sticky status flags.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            dl_q     <= 1'b0;
            addr_q   <= '0;
            ptr_k    <= '0;
            prg_end  <= '0;
            overflow <= 1'b0;
            err_drop <= 1'b0;
        end else begin
            dl_q <= ioctl_download;
            if (dl_rise) begin
                overflow <= 1'b0;
                err_drop <= 1'b0;
            end else if (ioctl_wr && full) begin
                err_drop <= 1'b1;
            end
            case (state_q)
                HDR: begin
                    if (wr_ok && ioctl_addr == IOCTL_AW'(0)) addr_q[7:0] <= ioctl_dout;
                    if (wr_ok && ioctl_addr == IOCTL_AW'(1)) addr_q[15:8] <= ioctl_dout;
                end
                DATA: begin
                    ptr_k <= '0;
                    if (wr_ok) begin
                        if (addr_q < RAM_LIMIT) addr_q <= addr_q + 16'd1;
                        else                    overflow <= 1'b1;
                    end
                end
                PTR_LO: begin
                    if (!dl_rise && !full && ptr_k == '0) prg_end <= addr_q;
                end
                PTR_HI: begin
                    if (!dl_rise && !full) ptr_k <= ptr_k + 1'b1;
                end
                default: ;
            endcase
        end
    end

    loader_wbuf u_wbuf (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .push      (push),
        .addr      (push_addr),
        .data      (push_data),
        .flush     (flush),
        .dma_ready (dma_ready),
        .full      (full),
        .dma_addr  (dma_addr),
        .dma_data  (dma_data),
        .dma_we    (dma_we)
    );

    assign ioctl_wait = full;
    assign busy       = (state_q != IDLE) | full;

endmodule

// File: tb/tb_prg_loader.sv
// tb/tb_prg_loader.sv - scoreboard bench for prg_loader
module tb_prg_loader;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;
    logic [15:0] dma_addr;
    logic [7:0]  dma_data;
    logic        dma_we;
    logic        dma_ready = 1'b1;
    logic        busy;
    logic [15:0] prg_end;
    logic        overflow;
    logic        err_drop;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [23:0] sb[$];
    logic [7:0]  payload[$];
    logic [15:0] exp_end;
    logic        stall_mode = 1'b0;
    int          stall_cnt  = 0;
    logic        prev_stall = 1'b0;
    logic [23:0] held       = '0;

    prg_loader dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .dma_addr       (dma_addr),
        .dma_data       (dma_data),
        .dma_we         (dma_we),
        .dma_ready      (dma_ready),
        .busy           (busy),
        .prg_end        (prg_end),
        .overflow       (overflow),
        .err_drop       (err_drop)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sink: ready always, or five stall cycles before every accept.
    always @(posedge clk_sys) begin
        #1;
        if (!stall_mode) begin
            dma_ready = 1'b1;
            stall_cnt = 0;
        end else if (dma_we) begin
            dma_ready = (stall_cnt >= 5);
            stall_cnt = (stall_cnt >= 5) ? 0 : stall_cnt + 1;
        end else begin
            dma_ready = 1'b0;
            stall_cnt = 0;
        end
    end

    // Monitor: pop and compare each accepted write, check hold stability during stalls.
    always @(negedge clk_sys) begin : mon
        logic [31:0] exp;
        if (prev_stall && dma_we) check("hold_stable", {8'h0, dma_addr, dma_data}, {8'h0, held});
        if (dma_we && !dma_ready) check("wait_in_stall", {31'h0, ioctl_wait}, 32'h1);
        if (dma_we && dma_ready) begin
            exp = (sb.size() > 0) ? {8'h01, sb.pop_front()} : 32'h0;
            check("dma_wr", {8'h01, dma_addr, dma_data}, exp);
        end
        prev_stall <= dma_we && !dma_ready && reset_n;
        held       <= {dma_addr, dma_data};
    end

    task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
        int n = 0;
        while (ioctl_wait && n < 500) begin
            @(posedge clk_sys); #1;
            n++;
        end
        if (n >= 500) check("wait_timeout", {31'h0, ioctl_wait}, 32'h0);
        ioctl_wr = 1'b1; ioctl_addr = a; ioctl_dout = d;
        @(posedge clk_sys); #1;
        ioctl_wr = 1'b0;
    endtask

    task automatic start_dl(input logic [7:0] idx);
        ioctl_index = idx;
        ioctl_download = 1'b1;
        repeat (2) begin @(posedge clk_sys); #1; end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((busy || sb.size() != 0) && n < 3000) begin
            @(negedge clk_sys);
            n++;
        end
        check(tag, {30'h0, busy, sb.size() != 0}, 32'h0);
    endtask

    // PRG download; drop_after >= 0 adds an unpaced strobe right after that payload byte.
    task automatic run_prg(input logic [15:0] hdr, input int drop_after);
        logic [15:0] a;
        a = hdr;
        start_dl(8'h41);
        send_byte(25'd0, hdr[7:0]);
        send_byte(25'd1, hdr[15:8]);
        foreach (payload[i]) begin
            if (a < 16'h8000) begin
                sb.push_back({a, payload[i]});
                a = a + 16'd1;
            end
            send_byte(25'(i + 2), payload[i]);
            if (i == drop_after) begin
                check("wait_before_drop", {31'h0, ioctl_wait}, 32'h1);
                ioctl_wr = 1'b1; ioctl_addr = 25'h99; ioctl_dout = 8'h55;
                @(posedge clk_sys); #1;
                ioctl_wr = 1'b0;
            end
        end
        for (int k = 0; k < 3; k++) begin
            sb.push_back({16'h002A + 16'(2 * k), a[7:0]});
            sb.push_back({16'h002B + 16'(2 * k), a[15:8]});
        end
        exp_end = a;
        ioctl_download = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [24:0] rom_offs[$];
        int n;
        rom_offs = '{25'h0000, 25'h0001, 25'h03FE, 25'h03FF, 25'h0400, 25'h0401,
                     25'h1234, 25'h7FFE, 25'h7FFF};
        reset_n = 1'b0; ioctl_download = 1'b0; ioctl_index = 8'h00;
        ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_dout = '0;
        repeat (2) @(posedge clk_sys);
        @(negedge clk_sys);
        check("rst_dma_we", {31'h0, dma_we}, 32'h0);
        check("rst_wait", {31'h0, ioctl_wait}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_dma_addr", {16'h0, dma_addr}, 32'h0);
        check("rst_dma_data", {24'h0, dma_data}, 32'h0);
        check("rst_prg_end", {16'h0, prg_end}, 32'h0);
        check("rst_flags", {30'h0, overflow, err_drop}, 32'h0);
        @(posedge clk_sys); #1;
        reset_n = 1'b1;
        @(posedge clk_sys); #1;

        // Basic PRG, sink always ready.
        payload = '{8'hAA, 8'hBB, 8'hCC};
        run_prg(16'h0401, -1);
        wait_idle("basic_idle");
        check("basic_prg_end", {16'h0, prg_end}, {16'h0, exp_end});
        check("basic_prg_end_lit", {16'h0, prg_end}, 32'h0404);
        check("basic_flags", {30'h0, overflow, err_drop}, 32'h0);

        // Same file with stalls, plus one strobe while the buffer is full.
        stall_mode = 1'b1;
        run_prg(16'h0401, 0);
        wait_idle("stall_idle");
        check("stall_err_drop", {31'h0, err_drop}, 32'h1);
        check("stall_prg_end", {16'h0, prg_end}, 32'h0404);
        stall_mode = 1'b0;

        // Header 7FFE with 4 payload bytes runs into RAM_LIMIT.
        payload = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_prg(16'h7FFE, -1);
        wait_idle("ovf_idle");
        check("ovf_flag", {31'h0, overflow}, 32'h1);
        check("ovf_err_clear", {31'h0, err_drop}, 32'h0);
        check("ovf_prg_end", {16'h0, prg_end}, 32'h8000);

        // Sparse ROM image with stalls; window and relocation.
        stall_mode = 1'b1;
        start_dl(8'h00);
        foreach (rom_offs[i]) begin
            if (rom_offs[i] >= 25'h0400 && rom_offs[i] < 25'h8000)
                sb.push_back({rom_offs[i][15:0] + 16'h8000, rom_offs[i][7:0] ^ 8'h5A});
            send_byte(rom_offs[i], rom_offs[i][7:0] ^ 8'h5A);
        end
        ioctl_download = 1'b0;
        @(negedge clk_sys);
        check("rom_busy_drain", {31'h0, busy}, 32'h1);
        wait_idle("rom_idle");
        check("rom_flags", {30'h0, overflow, err_drop}, 32'h0);
        check("rom_prg_end", {16'h0, prg_end}, 32'h8000);
        stall_mode = 1'b0;

        // One-byte PRG: header never completes.
        start_dl(8'h41);
        send_byte(25'd0, 8'h01);
        ioctl_download = 1'b0;
        @(posedge clk_sys);
        @(negedge clk_sys);
        check("short_busy", {31'h0, busy}, 32'h0);
        check("short_prg_end", {16'h0, prg_end}, 32'h8000);
        check("short_no_wr", {31'h0, dma_we}, 32'h0);

        // Reset while the k=1 pointer pair is in flight.
        payload = '{8'hAA, 8'hBB, 8'hCC};
        run_prg(16'h0401, -1);
        n = 0;
        while (!(dma_we && dma_addr == 16'h002C) && n < 500) begin
            @(posedge clk_sys); #1;
            n++;
        end
        check("ptr_k1_seen", {16'h0, dma_addr}, 32'h002C);
        reset_n = 1'b0;
        #1;
        check("mid_rst_dma_we", {31'h0, dma_we}, 32'h0);
        check("mid_rst_wait", {31'h0, ioctl_wait}, 32'h0);
        sb.delete();
        @(posedge clk_sys); #1;
        reset_n = 1'b1;
        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        check("post_rst_busy", {31'h0, busy}, 32'h0);
        check("post_rst_we", {31'h0, dma_we}, 32'h0);
        check("post_rst_prg_end", {16'h0, prg_end}, 32'h0);
        run_prg(16'h0401, -1);
        wait_idle("again_idle");
        check("again_prg_end", {16'h0, prg_end}, 32'h0404);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
